inst_fetch: RTL and testbench

//   Fetches 32-bit instructions from the instruction-memory port and pushes {epoch, pc, inst}

---
 rtl/rv_pkg.sv | 24 ++
 rtl/fetch_pc_reg.sv | 47 ++++
 rtl/inst_fetch.sv | 151 +++++++++++++++
 tb/tb_inst_fetch.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, PC step
// and the bit layout of a queue entry {epoch, pc, inst}.
package rv_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INST_W = 32;

  // Distance between consecutive sequential fetches (one 32-bit word).
  localparam int PC_STEP = 4;

  // Field offsets inside a queue entry for the default widths.
  localparam int INST_LSB  = 0;
  localparam int PC_LSB    = DEF_INST_W;
  localparam int EPOCH_BIT = DEF_ADDR_W + DEF_INST_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_PUSH = 3'd2,
    S_WACK = 3'd3,
    S_WREL = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC and epoch flop. A redirect loads the word-aligned target and
// flips the epoch; otherwise the PC advances by one word when told to.
module fetch_pc_reg
  import rv_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] fetch_pc_o,
  output logic              epoch_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              epoch_q, epoch_d;

  // Redirect has priority over the sequential increment; the add wraps freely.
  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (redirect_i) begin
      pc_d    = redirect_pc_i & ~ADDR_W'(3);
      epoch_d = ~epoch_q;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  // PC and epoch registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      epoch_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
  end

  assign fetch_pc_o = pc_q;
  assign epoch_o    = epoch_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: requests one word at a time from instruction memory and
// pushes {epoch, pc, inst} into the decode queue over a 4-phase handshake.
// Redirects from execute retarget the PC and flip the epoch; a request that
// cannot be aborted is tagged with kill so its data is thrown away.
//
//   state  | meaning
//   S_IDLE | ready to start a fetch at fetch_pc (held off by stall)
//   S_REQ  | memory request outstanding, waiting for mem_ack
//   S_PUSH | instruction held, waiting for queue space
//   S_WACK | buf_we high, waiting for buf_w_ack
//   S_WREL | buf_we low, waiting for buf_w_ack to drop
module inst_fetch
  import rv_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                OUT_L    = 1 + ADDR_W + INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              buf_we,
  output logic [OUT_L-1:0]  buf_din,
  input  logic              buf_w_ack,
  input  logic              buf_full,
  output logic              epoch,
  output logic [ADDR_W-1:0] fetch_pc
);

  fetch_state_e      state_q, state_d;
  logic              kill_q, kill_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              buf_we_q, buf_we_d;
  logic [OUT_L-1:0]  buf_din_q, buf_din_d;
  logic              pc_inc;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .inc_i         (pc_inc),
    .fetch_pc_o    (fetch_pc),
    .epoch_o       (epoch)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a redirect abandons work that has not reached the queue.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!redirect && !stall) state_d = S_REQ;
      S_REQ:  if (mem_ack) state_d = (kill_q || redirect) ? S_IDLE : S_PUSH;
      S_PUSH: begin
        if (redirect)       state_d = S_IDLE;
        else if (!buf_full) state_d = S_WACK;
      end
      S_WACK: if (buf_w_ack)  state_d = S_WREL;
      S_WREL: if (!buf_w_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; kill remembers a redirect seen mid-transaction.
  always_comb begin
    kill_d     = kill_q;
    inst_d     = inst_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    buf_we_d   = buf_we_q;
    buf_din_d  = buf_din_q;
    pc_inc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (!redirect && !stall) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc;
        end
      end
      S_REQ: begin
        if (redirect) kill_d = 1'b1;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          inst_d    = mem_rdata;
          if (kill_q || redirect) kill_d = 1'b0;
        end
      end
      S_PUSH: begin
        if (!redirect && !buf_full) begin
          buf_we_d  = 1'b1;
          buf_din_d = {epoch, fetch_pc, inst_q};
        end
      end
      S_WACK: begin
        if (redirect)  kill_d   = 1'b1;
        if (buf_w_ack) buf_we_d = 1'b0;
      end
      S_WREL: begin
        if (redirect) kill_d = 1'b1;
        if (!buf_w_ack) begin
          kill_d = 1'b0;
          pc_inc = !kill_q && !redirect;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and held instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kill_q     <= 1'b0;
      inst_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      buf_we_q   <= 1'b0;
      buf_din_q  <= '0;
    end else begin
      kill_q     <= kill_d;
      inst_q     <= inst_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      buf_we_q   <= buf_we_d;
      buf_din_q  <= buf_din_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign buf_we   = buf_we_q;
  assign buf_din  = buf_din_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: behavioural memory and queue responders, a scoreboard
// of expected queue entries, and a second instance with RESET_PC at the top
// of the address space to exercise PC wrap.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        buf_we, buf_w_ack, buf_full = 1'b0;
  logic [64:0] buf_din;
  logic        epoch;
  logic [31:0] fetch_pc;
  logic        mem_hold = 1'b0;

  // wrap instance
  logic        rst_w = 1'b0;
  logic        stall_w = 1'b0;
  logic        mem_req_w, mem_ack_w, buf_we_w, buf_w_ack_w, epoch_w;
  logic [31:0] mem_addr_w, mem_rdata_w, fetch_pc_w;
  logic [64:0] buf_din_w;

  int total = 0;
  int bad   = 0;
  int wr_count = 0;
  logic [64:0] exp_q[$];
  logic [64:0] got_w[$];
  logic        we_prev = 1'b0, we_prev_w = 1'b0;
  logic [64:0] din_prev = '0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .buf_we(buf_we), .buf_din(buf_din), .buf_w_ack(buf_w_ack), .buf_full(buf_full),
    .epoch(epoch), .fetch_pc(fetch_pc)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .stall(stall_w), .redirect(1'b0), .redirect_pc(32'h0),
    .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack_w), .mem_rdata(mem_rdata_w),
    .buf_we(buf_we_w), .buf_din(buf_din_w), .buf_w_ack(buf_w_ack_w), .buf_full(1'b0),
    .epoch(epoch_w), .fetch_pc(fetch_pc_w)
  );

  function automatic logic [31:0] inst_of(logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [64:0] entry(logic ep, logic [31:0] pc);
    return {ep, pc, inst_of(pc)};
  endfunction

  task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle memory unless held off by mem_hold.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack && !mem_hold) begin
        mem_ack   <= 1'b1;
        mem_rdata <= inst_of(mem_addr);
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) buf_w_ack <= 1'b0;
    else      buf_w_ack <= buf_we;
  end

  always @(posedge clk or negedge rst_w) begin
    if (!rst_w) begin
      mem_ack_w   <= 1'b0;
      mem_rdata_w <= '0;
      buf_w_ack_w <= 1'b0;
    end else begin
      mem_ack_w   <= mem_req_w && !mem_ack_w;
      mem_rdata_w <= inst_of(mem_addr_w);
      buf_w_ack_w <= buf_we_w;
    end
  end

  // Queue-side monitor: score each write strobe and watch payload stability.
  always @(negedge clk) begin
    if (!rst) begin
      we_prev = 1'b0;
    end else begin
      if (buf_we && !we_prev) begin
        wr_count++;
        chk("sb_nonempty", 96'(exp_q.size() != 0), 96'd1);
        if (exp_q.size() != 0) chk("entry", 96'(buf_din), 96'(exp_q.pop_front()));
      end else if (buf_we && we_prev) begin
        chk("din_stable", 96'(buf_din), 96'(din_prev));
      end
      we_prev  = buf_we;
      din_prev = buf_din;
    end
    if (buf_we_w && !we_prev_w) begin
      got_w.push_back(buf_din_w);
      if (got_w.size() >= 2) stall_w = 1'b1;
    end
    we_prev_w = buf_we_w;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_writes(int n, string tag);
    for (int i = 0; i < 60; i++) begin
      if (wr_count >= n) break;
      cyc();
    end
    chk(tag, 96'(wr_count), 96'(n));
  endtask

  task automatic wait_req(logic lvl, string tag);
    for (int i = 0; i < 20; i++) begin
      if (mem_req == lvl) break;
      cyc();
    end
    chk(tag, 96'(mem_req), 96'(lvl));
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b1; redirect = 1'b0; buf_full = 1'b0; mem_hold = 1'b0;
    repeat (3) cyc();
    chk("rst_mem_req", 96'(mem_req), 96'd0);
    chk("rst_mem_addr", 96'(mem_addr), 96'd0);
    chk("rst_buf_we", 96'(buf_we), 96'd0);
    chk("rst_buf_din", 96'(buf_din), 96'd0);
    chk("rst_epoch", 96'(epoch), 96'd0);
    chk("rst_fetch_pc", 96'(fetch_pc), 96'd0);
    rst = 1'b1;
    cyc();
  endtask

  task automatic pulse_redirect(logic [31:0] pc);
    redirect = 1'b1; redirect_pc = pc;
    cyc();
    redirect = 1'b0;
  endtask

  initial begin
    int base;
    repeat (2) cyc();
    rst_w = 1'b1;

    // 1: three sequential fetches
    do_reset();
    base = wr_count;
    exp_q.push_back(entry(1'b0, 32'h0));
    exp_q.push_back(entry(1'b0, 32'h4));
    exp_q.push_back(entry(1'b0, 32'h8));
    stall = 1'b0;
    wait_writes(base + 3, "t1_writes");
    stall = 1'b1;
    repeat (10) cyc();
    chk("t1_count", 96'(wr_count), 96'(base + 3));
    chk("t1_next_pc", 96'(fetch_pc), 96'h0C);
    chk("t1_drain", 96'(exp_q.size()), 96'd0);

    // 2: queue full at second push
    do_reset();
    base = wr_count;
    exp_q.push_back(entry(1'b0, 32'h0));
    exp_q.push_back(entry(1'b0, 32'h4));
    stall = 1'b0;
    wait_writes(base + 1, "t2_first");
    buf_full = 1'b1;
    for (int i = 0; i < 10 && buf_we; i++) cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t2_full_hold", 96'(buf_we), 96'd0);
    end
    buf_full = 1'b0;
    wait_writes(base + 2, "t2_second");
    stall = 1'b1;
    repeat (10) cyc();
    chk("t2_once", 96'(wr_count), 96'(base + 2));
    chk("t2_drain", 96'(exp_q.size()), 96'd0);

    // 3: redirect while the memory request is outstanding
    do_reset();
    base = wr_count;
    exp_q.push_back(entry(1'b1, 32'h100));
    mem_hold = 1'b1;
    stall = 1'b0;
    wait_req(1'b1, "t3_req");
    pulse_redirect(32'h103);
    chk("t3_epoch", 96'(epoch), 96'd1);
    chk("t3_pc", 96'(fetch_pc), 96'h100);
    chk("t3_req_held", 96'(mem_req), 96'd1);
    chk("t3_addr_held", 96'(mem_addr), 96'h0);
    repeat (2) cyc();
    mem_hold = 1'b0;
    wait_req(1'b0, "t3_req_drop");
    wait_req(1'b1, "t3_req_again");
    chk("t3_refetch_addr", 96'(mem_addr), 96'h100);
    wait_writes(base + 1, "t3_write");
    stall = 1'b1;
    repeat (10) cyc();
    chk("t3_count", 96'(wr_count), 96'(base + 1));
    chk("t3_drain", 96'(exp_q.size()), 96'd0);

    // 4: redirect while the queue handshake is in progress
    do_reset();
    base = wr_count;
    exp_q.push_back(entry(1'b0, 32'h0));
    exp_q.push_back(entry(1'b1, 32'h200));
    stall = 1'b0;
    wait_writes(base + 1, "t4_first");
    pulse_redirect(32'h200);
    wait_writes(base + 2, "t4_second");
    stall = 1'b1;
    repeat (10) cyc();
    chk("t4_count", 96'(wr_count), 96'(base + 2));
    chk("t4_next_pc", 96'(fetch_pc), 96'h204);
    chk("t4_drain", 96'(exp_q.size()), 96'd0);

    // 6: reset asserted in the middle of the write handshake
    do_reset();
    base = wr_count;
    pulse_redirect(32'h40);
    exp_q.push_back(entry(1'b1, 32'h40));
    stall = 1'b0;
    wait_writes(base + 1, "t6_first");
    chk("t6_we_high", 96'(buf_we), 96'd1);
    #1 rst = 1'b0;
    #1;
    chk("t6_we_drop", 96'(buf_we), 96'd0);
    chk("t6_req_drop", 96'(mem_req), 96'd0);
    chk("t6_epoch", 96'(epoch), 96'd0);
    chk("t6_pc", 96'(fetch_pc), 96'h0);
    cyc();
    rst = 1'b1;
    exp_q.push_back(entry(1'b0, 32'h0));
    cyc();
    wait_writes(base + 2, "t6_restart");
    stall = 1'b1;
    repeat (10) cyc();
    chk("t6_drain", 96'(exp_q.size()), 96'd0);

    // 5: wrap instance has been running since the start
    chk("t5_count", 96'(got_w.size()), 96'd2);
    if (got_w.size() >= 2) begin
      chk("t5_first", 96'(got_w[0]), 96'(entry(1'b0, 32'hFFFF_FFFC)));
      chk("t5_wrap", 96'(got_w[1]), 96'(entry(1'b0, 32'h0)));
    end
    chk("t5_epoch", 96'(epoch_w), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
